// File: rtl/pcpu_pipeline_if.sv
// Harvard memory bus for the pcpu_pipeline core: instruction ROM port and
// data RAM port, both read combinationally by the core.
interface pcpu_pipeline_if;
    logic [31:0] inst_addr;
    logic [31:0] inst_mem;
    logic [31:0] data_addr;
    logic [31:0] data_mem;
    logic        data_we;
    logic [31:0] data_write;

    modport master (
        output inst_addr,
        output data_addr,
        output data_we,
        output data_write,
        input  inst_mem,
        input  data_mem
    );

    modport slave (
        input  inst_addr,
        input  data_addr,
        input  data_we,
        input  data_write,
        output inst_mem,
        output data_mem
    );
endinterface

// File: rtl/pcpu_pipeline.sv
// Five-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB).
// Supports add/sub/and/or/slt, addi, lw, sw, beq and j; anything else is a NOP.
// Build option FORWARDING_EN: when defined, EX operands are bypassed from
// EX/MEM and MEM/WB and only a load-use pair stalls (1 cycle). When undefined,
// ID stalls until its producers have left EX and MEM, relying on the register
// file write-through for the final hop.
module pcpu_pipeline #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    pcpu_pipeline_if.master bus
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } aluOp_e;

    typedef struct packed {
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        branch;
        logic        aluSrc;
        aluOp_e      aluOp;
        logic [4:0]  dest;
        logic [31:0] rsVal;
        logic [31:0] rtVal;
        logic [31:0] imm;
        logic [31:0] pc4;
    } idex_t;

    typedef struct packed {
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] storeData;
    } exmem_t;

    typedef struct packed {
        logic        regWrite;
        logic [4:0]  dest;
        logic [31:0] value;
    } memwb_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifidInst_q, ifidInst_d;
    logic [31:0] ifidPc4_q, ifidPc4_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    logic [31:0] regFile_q [32];

    logic [5:0]  idOpcode, idFunct;
    logic [4:0]  idRs, idRt, idRd;
    logic [31:0] idImm, idRsVal, idRtVal;

    logic        decRegWrite, decMemRead, decMemWrite, decBranch, decAluSrc, decJump;
    aluOp_e      decAluOp;
    logic [4:0]  decDest;

    logic        stall;
    logic [31:0] exOpA, exOpB, aluB, aluResult, branchTarget, memValue;
    logic        branchTaken;

    assign idOpcode = ifidInst_q[31:26];
    assign idRs     = ifidInst_q[25:21];
    assign idRt     = ifidInst_q[20:16];
    assign idRd     = ifidInst_q[15:11];
    assign idFunct  = ifidInst_q[5:0];
    assign idImm    = {{16{ifidInst_q[15]}}, ifidInst_q[15:0]};

    // Register reads in ID; a same-cycle WB write to the register is passed straight through
    assign idRsVal = (idRs == 5'd0) ? 32'd0 :
                     (memwb_q.regWrite && memwb_q.dest == idRs) ? memwb_q.value : regFile_q[idRs];
    assign idRtVal = (idRt == 5'd0) ? 32'd0 :
                     (memwb_q.regWrite && memwb_q.dest == idRt) ? memwb_q.value : regFile_q[idRt];

    // Instruction decode into control signals; unknown encodings stay all-zero (NOP)
    always_comb begin
        decRegWrite = 1'b0;
        decMemRead  = 1'b0;
        decMemWrite = 1'b0;
        decBranch   = 1'b0;
        decAluSrc   = 1'b0;
        decJump     = 1'b0;
        decAluOp    = ALU_ADD;
        decDest     = idRd;
        case (idOpcode)
            6'h00: begin
                case (idFunct)
                    6'h20: begin decRegWrite = 1'b1; decAluOp = ALU_ADD; end
                    6'h22: begin decRegWrite = 1'b1; decAluOp = ALU_SUB; end
                    6'h24: begin decRegWrite = 1'b1; decAluOp = ALU_AND; end
                    6'h25: begin decRegWrite = 1'b1; decAluOp = ALU_OR;  end
                    6'h2A: begin decRegWrite = 1'b1; decAluOp = ALU_SLT; end
                    default: ;
                endcase
            end
            6'h08: begin decRegWrite = 1'b1; decAluSrc = 1'b1; decDest = idRt; end
            6'h23: begin decRegWrite = 1'b1; decMemRead = 1'b1; decAluSrc = 1'b1; decDest = idRt; end
            6'h2B: begin decMemWrite = 1'b1; decAluSrc = 1'b1; end
            6'h04: decBranch = 1'b1;
            6'h02: decJump   = 1'b1;
            default: ;
        endcase
        if (decDest == 5'd0) begin
            decRegWrite = 1'b0;
        end
    end

`ifdef FORWARDING_EN
    logic [4:0] idexRs_q, idexRt_q;

    // Source register numbers of the EX instruction, needed only for bypass matching
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idexRs_q <= 5'd0;
            idexRt_q <= 5'd0;
        end else begin
            idexRs_q <= idRs;
            idexRt_q <= idRt;
        end
    end

    // Only a load feeding the very next instruction has to wait one cycle
    assign stall = idex_q.memRead && (idex_q.dest != 5'd0) &&
                   (idex_q.dest == idRs || idex_q.dest == idRt);

    // EX operand bypass: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        exOpA = idex_q.rsVal;
        exOpB = idex_q.rtVal;
        if (exmem_q.regWrite && exmem_q.dest != 5'd0 && exmem_q.dest == idexRs_q) begin
            exOpA = exmem_q.result;
        end else if (memwb_q.regWrite && memwb_q.dest != 5'd0 && memwb_q.dest == idexRs_q) begin
            exOpA = memwb_q.value;
        end
        if (exmem_q.regWrite && exmem_q.dest != 5'd0 && exmem_q.dest == idexRt_q) begin
            exOpB = exmem_q.result;
        end else if (memwb_q.regWrite && memwb_q.dest != 5'd0 && memwb_q.dest == idexRt_q) begin
            exOpB = memwb_q.value;
        end
    end
`else
    // Hold ID while any producer of its sources is still in EX or MEM
    assign stall = (idex_q.regWrite && idex_q.dest != 5'd0 &&
                    (idex_q.dest == idRs || idex_q.dest == idRt)) ||
                   (exmem_q.regWrite && exmem_q.dest != 5'd0 &&
                    (exmem_q.dest == idRs || exmem_q.dest == idRt));

    // Without bypass paths the operands read in ID are already current
    always_comb begin
        exOpA = idex_q.rsVal;
        exOpB = idex_q.rtVal;
    end
`endif

    assign aluB         = idex_q.aluSrc ? idex_q.imm : exOpB;
    assign branchTaken  = idex_q.branch && (exOpA == exOpB);
    assign branchTarget = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};
    assign memValue     = exmem_q.memRead ? bus.data_mem : exmem_q.result;

    // ALU: wrapping add/sub, bitwise and/or, signed set-less-than
    always_comb begin
        case (idex_q.aluOp)
            ALU_ADD: aluResult = exOpA + aluB;
            ALU_SUB: aluResult = exOpA - aluB;
            ALU_AND: aluResult = exOpA & aluB;
            ALU_OR:  aluResult = exOpA | aluB;
            ALU_SLT: aluResult = {31'd0, $signed(exOpA) < $signed(aluB)};
            default: aluResult = 32'd0;
        endcase
    end

    // Next pipeline state: taken branch beats stall, stall beats jump, else advance
    always_comb begin
        pc_d       = pc_q + 32'd4;
        ifidInst_d = bus.inst_mem;
        ifidPc4_d  = pc_q + 32'd4;

        idex_d.regWrite = decRegWrite;
        idex_d.memRead  = decMemRead;
        idex_d.memWrite = decMemWrite;
        idex_d.branch   = decBranch;
        idex_d.aluSrc   = decAluSrc;
        idex_d.aluOp    = decAluOp;
        idex_d.dest     = decDest;
        idex_d.rsVal    = idRsVal;
        idex_d.rtVal    = idRtVal;
        idex_d.imm      = idImm;
        idex_d.pc4      = ifidPc4_q;

        exmem_d.regWrite  = idex_q.regWrite;
        exmem_d.memRead   = idex_q.memRead;
        exmem_d.memWrite  = idex_q.memWrite;
        exmem_d.dest      = idex_q.dest;
        exmem_d.result    = aluResult;
        exmem_d.storeData = exOpB;

        memwb_d.regWrite = exmem_q.regWrite;
        memwb_d.dest     = exmem_q.dest;
        memwb_d.value    = memValue;

        if (branchTaken) begin
            pc_d       = branchTarget;
            ifidInst_d = 32'd0;
            ifidPc4_d  = 32'd0;
            idex_d     = '0;
        end else if (stall) begin
            pc_d       = pc_q;
            ifidInst_d = ifidInst_q;
            ifidPc4_d  = ifidPc4_q;
            idex_d     = '0;
        end else if (decJump) begin
            pc_d       = {ifidPc4_q[31:28], ifidInst_q[25:0], 2'b00};
            ifidInst_d = 32'd0;
            ifidPc4_d  = 32'd0;
        end
    end

    // Pipeline registers; reset fills every stage with a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            ifidInst_q <= 32'd0;
            ifidPc4_q  <= 32'd0;
            idex_q     <= '0;
            exmem_q    <= '0;
            memwb_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            ifidInst_q <= ifidInst_d;
            ifidPc4_q  <= ifidPc4_d;
            idex_q     <= idex_d;
            exmem_q    <= exmem_d;
            memwb_q    <= memwb_d;
        end
    end

    // Register file write in WB; r0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regFile_q[i] <= 32'd0;
            end
        end else if (memwb_q.regWrite && memwb_q.dest != 5'd0) begin
            regFile_q[memwb_q.dest] <= memwb_q.value;
        end
    end

    assign bus.inst_addr  = pc_q;
    assign bus.data_addr  = exmem_q.result;
    assign bus.data_we    = exmem_q.memWrite;
    assign bus.data_write = exmem_q.storeData;

endmodule

// File: tb/tb_pcpu_pipeline.sv
// Directed bench for pcpu_pipeline: reset, ALU chains, load-use, branches,
// jump/r0 handling and asynchronous reset during a store.
// Cycle-count expectations follow the FORWARDING_EN build setting.
module tb_pcpu_pipeline;

    logic clk;
    logic rst;

    pcpu_pipeline_if bus ();

    pcpu_pipeline #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom [64];
    logic [31:0] ram [64];

    int          totalCount;
    int          badCount;
    int          weCount;
    logic [31:0] lastWeAddr;
    logic [31:0] lastWeData;

`ifdef FORWARDING_EN
    localparam logic [31:0] ALU_PC_AT5  = 32'h14;
    localparam logic [31:0] LU_PC_AT6   = 32'h14;
    localparam int          BR_CYCLES   = 4;
    localparam logic [31:0] BRNT_PC_AT5 = 32'h14;
`else
    localparam logic [31:0] ALU_PC_AT5  = 32'h0c;
    localparam logic [31:0] LU_PC_AT6   = 32'h10;
    localparam int          BR_CYCLES   = 6;
    localparam logic [31:0] BRNT_PC_AT5 = 32'h0c;
`endif

    assign bus.inst_mem = rom[bus.inst_addr[7:2]];
    assign bus.data_mem = ram[bus.data_addr[7:2]];

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] encJ(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalCount++;
        assert (observed === expected)
        else begin
            badCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic holdReset();
        rst = 1'b0;
        weCount = 0;
        lastWeAddr = 32'd0;
        lastWeData = 32'd0;
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'd0;
            ram[i] = 32'd0;
        end
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Advance n clocks from a negedge; the RAM model commits stores on each posedge
    task automatic applyStimulus(input int n);
        logic        pendWe;
        logic [31:0] pendAddr;
        logic [31:0] pendData;
        for (int i = 0; i < n; i++) begin
            pendWe   = bus.data_we;
            pendAddr = bus.data_addr;
            pendData = bus.data_write;
            @(posedge clk);
            if (pendWe) ram[pendAddr[7:2]] = pendData;
            @(negedge clk);
            if (bus.data_we) begin
                weCount++;
                lastWeAddr = bus.data_addr;
                lastWeData = bus.data_write;
            end
        end
    endtask

    initial begin
        int guard;
        totalCount = 0;
        badCount   = 0;

        // Reset state and sequential fetch from RESET_PC
        holdReset();
        @(negedge clk);
        checkOutput("rstInstAddr", bus.inst_addr, 32'h0);
        checkOutput("rstDataWe", {31'd0, bus.data_we}, 32'h0);
        checkOutput("rstDataAddr", bus.data_addr, 32'h0);
        checkOutput("rstDataWrite", bus.data_write, 32'h0);
        releaseReset();
        checkOutput("releasePc0", bus.inst_addr, 32'h0);
        applyStimulus(1);
        checkOutput("releasePc4", bus.inst_addr, 32'h4);
        applyStimulus(1);
        checkOutput("releasePc8", bus.inst_addr, 32'h8);
        applyStimulus(3);
        checkOutput("bubbleNoWrite", weCount, 32'd0);

        // Back-to-back ALU chain plus wrap and signed-compare corners
        holdReset();
        rom[0]  = encI(6'h08, 5'd0, 5'd1, 16'd5);
        rom[1]  = encI(6'h08, 5'd0, 5'd2, 16'd7);
        rom[2]  = encR(5'd1, 5'd2, 5'd3, 6'h20);
        rom[3]  = encR(5'd3, 5'd1, 5'd4, 6'h22);
        rom[4]  = encR(5'd4, 5'd3, 5'd5, 6'h2A);
        rom[5]  = encR(5'd1, 5'd2, 5'd6, 6'h24);
        rom[6]  = encR(5'd1, 5'd2, 5'd7, 6'h25);
        rom[7]  = encR(5'd1, 5'd2, 5'd8, 6'h22);
        rom[8]  = encR(5'd8, 5'd1, 5'd9, 6'h2A);
        rom[9]  = encI(6'h08, 5'd0, 5'd10, 16'hFFFF);
        rom[10] = encI(6'h08, 5'd10, 5'd11, 16'd1);
        releaseReset();
        applyStimulus(5);
        checkOutput("aluIssuePc", bus.inst_addr, ALU_PC_AT5);
        applyStimulus(40);
        checkOutput("aluAddR3", dut.regFile_q[3], 32'd12);
        checkOutput("aluSubR4", dut.regFile_q[4], 32'd7);
        checkOutput("aluSltR5", dut.regFile_q[5], 32'd1);
        checkOutput("aluAndR6", dut.regFile_q[6], 32'd5);
        checkOutput("aluOrR7", dut.regFile_q[7], 32'd7);
        checkOutput("aluSubNegR8", dut.regFile_q[8], 32'hFFFF_FFFE);
        checkOutput("aluSltSignedR9", dut.regFile_q[9], 32'd1);
        checkOutput("addiSextR10", dut.regFile_q[10], 32'hFFFF_FFFF);
        checkOutput("addiWrapR11", dut.regFile_q[11], 32'd0);

        // Store, load and a dependent use of the loaded value
        holdReset();
        rom[0] = encI(6'h08, 5'd0, 5'd1, 16'h0040);
        rom[1] = encI(6'h2B, 5'd1, 5'd1, 16'h0000);
        rom[2] = encI(6'h23, 5'd1, 5'd2, 16'h0000);
        rom[3] = encR(5'd2, 5'd2, 5'd3, 6'h20);
        releaseReset();
        applyStimulus(6);
        checkOutput("loadUsePc", bus.inst_addr, LU_PC_AT6);
        applyStimulus(14);
        checkOutput("swWeCount", weCount, 32'd1);
        checkOutput("swDataAddr", lastWeAddr, 32'h40);
        checkOutput("swDataWrite", lastWeData, 32'h40);
        checkOutput("ramWord10", ram[16], 32'h40);
        checkOutput("lwR2", dut.regFile_q[2], 32'h40);
        checkOutput("loadUseR3", dut.regFile_q[3], 32'h80);

        // Taken branch squashes its two shadow instructions
        holdReset();
        rom[0] = encI(6'h08, 5'd0, 5'd1, 16'd3);
        rom[1] = encI(6'h04, 5'd1, 5'd1, 16'd2);
        rom[2] = encI(6'h08, 5'd0, 5'd6, 16'd1);
        rom[3] = encI(6'h08, 5'd0, 5'd6, 16'd2);
        rom[4] = encI(6'h08, 5'd0, 5'd8, 16'd9);
        releaseReset();
        applyStimulus(BR_CYCLES);
        checkOutput("beqTargetPc", bus.inst_addr, 32'h10);
        applyStimulus(10);
        checkOutput("beqShadowR6", dut.regFile_q[6], 32'd0);
        checkOutput("beqLandR8", dut.regFile_q[8], 32'd9);

        // Not-taken branch falls through without losing cycles
        holdReset();
        rom[0] = encI(6'h08, 5'd0, 5'd1, 16'd3);
        rom[1] = encI(6'h04, 5'd1, 5'd0, 16'd2);
        rom[2] = encI(6'h08, 5'd0, 5'd6, 16'd1);
        rom[3] = encI(6'h08, 5'd0, 5'd9, 16'd2);
        rom[4] = encI(6'h08, 5'd0, 5'd8, 16'd9);
        releaseReset();
        applyStimulus(5);
        checkOutput("beqNtPc", bus.inst_addr, BRNT_PC_AT5);
        applyStimulus(10);
        checkOutput("beqNtR6", dut.regFile_q[6], 32'd1);
        checkOutput("beqNtR9", dut.regFile_q[9], 32'd2);
        checkOutput("beqNtR8", dut.regFile_q[8], 32'd9);

        // Jump skips one slot; r0 ignores writes
        holdReset();
        rom[0] = encJ(26'd8);
        rom[1] = encI(6'h08, 5'd0, 5'd7, 16'd1);
        rom[8] = encI(6'h08, 5'd0, 5'd0, 16'd9);
        rom[9] = encI(6'h2B, 5'd0, 5'd0, 16'h0044);
        ram[17] = 32'hDEAD_BEEF;
        releaseReset();
        applyStimulus(1);
        checkOutput("jumpSlotPc", bus.inst_addr, 32'h4);
        applyStimulus(1);
        checkOutput("jumpTargetPc", bus.inst_addr, 32'h20);
        applyStimulus(10);
        checkOutput("jumpSkippedR7", dut.regFile_q[7], 32'd0);
        checkOutput("r0StaysZero", dut.regFile_q[0], 32'd0);
        checkOutput("r0StoresZero", ram[17], 32'd0);

        // Asynchronous reset while a store sits in MEM
        holdReset();
        rom[0] = encI(6'h08, 5'd0, 5'd1, 16'h0040);
        rom[1] = encI(6'h2B, 5'd1, 5'd1, 16'h0000);
        releaseReset();
        guard = 0;
        while (!bus.data_we && guard < 20) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput("swReachedMem", {31'd0, bus.data_we}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("asyncWeDrop", {31'd0, bus.data_we}, 32'd0);
        checkOutput("asyncInstAddr", bus.inst_addr, 32'h0);
        checkOutput("asyncDataAddr", bus.data_addr, 32'h0);
        for (int r = 0; r < 32; r++) begin
            checkOutput($sformatf("asyncReg%0d", r), dut.regFile_q[r], 32'd0);
        end
        @(posedge clk);
        #1;
        if (bus.data_we) ram[bus.data_addr[7:2]] = bus.data_write;
        checkOutput("asyncNoRamWrite", ram[16], 32'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/pcpu_pipeline.md
Name: pcpu_pipeline

Overview:
Five-stage in-order pipelined 32-bit MIPS-subset CPU: IF, ID, EX, MEM, WB. Top-level core of the processor.
Harvard interface to an external instruction ROM and data RAM, both read combinationally. Data RAM is written on the posedge of clk when data_we is 1.
Includes forwarding, a load-use interlock and branch/jump flushing.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset.
inst_addr  output  32  PC of the IF stage; word-aligned byte address.
inst_mem  input  32  instruction at inst_addr, valid in the same cycle.
data_addr  output  32  MEM-stage ALU result; byte address for lw/sw.
data_mem  input  32  RAM word at data_addr, valid in the same cycle.
data_we  output  1  1 while a sw is in the MEM stage.
data_write  output  32  store data (forwarded rt value) for the sw in MEM.

Behaviour:
- Reset (rst=0, asynchronous):
  - PC = RESET_PC.
  - All 32 registers = 0.
  - Every pipeline register holds a bubble (all control signals 0).
  - So inst_addr = RESET_PC, data_we = 0, data_addr = 0, data_write = 0.
- Reset mid-execution aborts all in-flight instructions. No partial writes: data_we drops at once.
- ISA uses standard MIPS encodings:
  - R-type (opcode 0) funct codes: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - I-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02.
  - Any other opcode or funct executes as a NOP.
- Arithmetic:
  - add, sub and addi wrap modulo 2^32; there is no overflow trap.
  - slt is a signed compare giving 1 or 0.
  - addi, lw, sw and beq sign-extend the 16-bit immediate.
- Register file:
  - r0 always reads 0; writes to r0 are dropped.
  - Reads are combinational in ID.
  - A WB write to the same register is bypassed into the ID read in the same cycle (write-through).
- Memory access: word-only, with bits [1:0] of data_addr ignored. lw writes data_mem to rt in WB.
- PC update each cycle, highest priority first:
  1. Taken beq in EX: PC = branch target. Flush the IF/ID and ID/EX entries (2 bubbles).
  2. Stall: hold PC and IF/ID; insert a bubble into ID/EX.
  3. j in ID: PC = {PC+4[31:28], target26, 2'b00}, where PC+4 is the j instruction's own PC+4. Flush IF/ID (1 bubble).
  4. Otherwise PC = PC+4.
- beq:
  - Compares forwarded rs and rt in EX.
  - Target = PC_beq + 4 + (sext(imm) << 2).
  - Not-taken costs 0 cycles.
- Forwarding (EX-stage operands):
  - The EX/MEM result takes priority over the MEM/WB result.
  - A source is forwarded only if it is nonzero and the producer writes that register.
  - The sw store data is forwarded the same way.
- Load-use stall: if the ID/EX instruction is a lw whose rt is non-zero and equals the ID instruction's rs or rt, stall exactly 1 cycle.
- Result latency: a result is visible to the immediately following instruction, with no stall except load-use.
- Bubbles never write registers or memory.

Optional Feature:
FORWARDING_EN
- Defined: forwarding and a 1-cycle load-use stall, as described above.
- Undefined: no forwarding paths. The ID stage stalls while any instruction in EX or MEM writes a non-zero register equal to ID's rs or rt.
  - The WB write-through in the register file still applies.
  - A dependent instruction therefore issues 2 cycles behind its producer.
  - Architectural results are identical either way; only cycle counts differ.

Test Plan:
- Reset: hold rst=0, then release. Required: inst_addr = 0 at release. It then increments by 4 each posedge (0, 4, 8), and data_we stays 0 throughout the bubbles.
- Back-to-back ALU: addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sub r4,r3,r1; slt r5,r4,r3. Required: r3=12, r4=7, r5=1, with no stall cycles (FORWARDING_EN defined).
- Load-use: addi r1,r0,0x40; sw r1,0(r1); lw r2,0(r1); add r3,r2,r2. Required: RAM[0x10]=0x40 and r3=0x80. Exactly one bubble is inserted after the lw, and data_we is high for one cycle with data_addr=0x40 and data_write=0x40.
- Branch: addi r1,r0,3; beq r1,r1,+2 with two addi r6 ops in the shadow. Required: the shadow ops never write r6 (stays 0) and fetch resumes at the target. Repeated with unequal operands: fall-through with no lost cycles.
- Jump and r0: j to word 8; the skipped slot holds addi r7,r0,1; addi r0,r0,9. Required: r7=0, r0 reads 0, and inst_addr goes to 0x20 after exactly one bubble.
- Async reset mid-run: assert rst=0 between clock edges during a sw in MEM. Required: data_we falls immediately, inst_addr=0, and all registers read 0.
